// File: rtl/ram_resp_pkg.sv
// ram_resp_pkg: shared states, default parameters and address width for ram_byte_responder
package ram_resp_pkg;
  localparam int ADDR_W = 26;
  localparam int DEF_MEM_AW = 12;
  localparam int DEF_READ_LAT = 2;
  localparam int DEF_WR_LAT = 1;
  localparam int DEF_INIT_CYCLES = 16;
  localparam int CNT_W = 16;
  typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_WRITE, ST_READ, ST_PRESENT} state_t;
endpackage

// File: rtl/byte_bram.sv
// byte_bram: single-port 8-bit synchronous RAM with registered read
// Ports: systemCLK clock; i_we write strobe; i_addr word address;
//        i_din write byte; o_dout byte at the address of the previous cycle.
module byte_bram #(
  parameter int AW = 12
) (
  input  logic          systemCLK,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_din,
  output logic [7:0]    o_dout
);
  logic [7:0] r_mem [2**AW];
  logic [7:0] r_q;
  always_ff @(posedge systemCLK) begin
    if (i_we) r_mem[i_addr] <= i_din;
    r_q <= r_mem[i_addr];
  end
  assign o_dout = r_q;
endmodule

// File: rtl/ram_byte_responder.sv
// ram_byte_responder: BRAM-backed stand-in for the DDR2 byte request/ack wrapper
// Ports: systemCLK/reset (sync, active-high); address/data_in command inputs;
//        write_enable/read_request act on rising edges; read_ack consumes data_out;
//        rdy accepting commands; rd_data_pres data_out valid; max_ram_address top byte;
//        cmd_drop/addr_err one-cycle error pulses.
module ram_byte_responder
  import ram_resp_pkg::*;
#(
  parameter int MEM_AW = DEF_MEM_AW,
  parameter int READ_LAT = DEF_READ_LAT,
  parameter int WR_LAT = DEF_WR_LAT,
  parameter int INIT_CYCLES = DEF_INIT_CYCLES
) (
  input  logic              systemCLK,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [7:0]        data_in,
  input  logic              write_enable,
  input  logic              read_request,
  input  logic              read_ack,
  output logic [7:0]        data_out,
  output logic              rdy,
  output logic              rd_data_pres,
  output logic [ADDR_W-1:0] max_ram_address,
  output logic              cmd_drop,
  output logic              addr_err
);
  state_t r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_lim;
  logic r_we_q, r_rr_q, r_pend, r_oor, r_cmd_drop, r_addr_err;
  logic [MEM_AW-1:0] r_addr, w_ram_addr;
  logic [7:0] r_data_out, w_q;
  logic w_rdy, w_we_edge, w_rr_edge, w_acc_wr, w_acc_rd, w_in_range, w_done;
  assign w_rdy = r_state == ST_IDLE || r_state == ST_PRESENT;
  assign w_we_edge = write_enable & ~r_we_q;
  assign w_rr_edge = read_request & ~r_rr_q;
  assign w_acc_wr = w_rdy & w_we_edge;
  assign w_acc_rd = w_rdy & w_rr_edge;
  assign w_in_range = address[ADDR_W-1:MEM_AW] == '0;
  assign w_lim = r_state == ST_INIT ? CNT_W'(INIT_CYCLES - 1) :
                 r_state == ST_WRITE ? CNT_W'(WR_LAT - 1) : CNT_W'(READ_LAT - 1);
  assign w_done = r_cnt == w_lim;
  // Outside the accepting states the RAM reads the latched address, so a pending
  // read after WRITE sees the byte just written.
  assign w_ram_addr = w_rdy ? address[MEM_AW-1:0] : r_addr;
  byte_bram #(.AW(MEM_AW)) u_ram (
    .systemCLK(systemCLK),
    .i_we(w_acc_wr & w_in_range),
    .i_addr(w_ram_addr),
    .i_din(data_in),
    .o_dout(w_q)
  );
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: w_state_nxt = w_done ? ST_IDLE : ST_INIT;
      ST_WRITE: w_state_nxt = w_done ? (r_pend ? ST_READ : ST_IDLE) : ST_WRITE;
      ST_READ: w_state_nxt = w_done ? ST_PRESENT : ST_READ;
      default: w_state_nxt = w_acc_wr ? ST_WRITE : w_acc_rd ? ST_READ :
                             (r_state == ST_PRESENT && read_ack) ? ST_IDLE : r_state;
    endcase
  end
  always_ff @(posedge systemCLK) begin
    if (reset) begin
      r_state <= ST_INIT;
      r_cnt <= '0;
      r_we_q <= 1'b0;
      r_rr_q <= 1'b0;
      r_pend <= 1'b0;
      r_oor <= 1'b0;
      r_addr <= '0;
      r_data_out <= 8'h00;
      r_cmd_drop <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_state_nxt != r_state ? '0 : r_cnt + CNT_W'(1);
      r_we_q <= write_enable;
      r_rr_q <= read_request;
      r_pend <= (w_acc_wr & w_acc_rd) | (r_pend & ~(r_state == ST_WRITE && w_done));
      r_cmd_drop <= (w_we_edge | w_rr_edge) & ~w_rdy;
      r_addr_err <= (w_acc_wr | w_acc_rd) & ~w_in_range;
      if (w_acc_rd) begin
        r_addr <= address[MEM_AW-1:0];
        r_oor <= ~w_in_range;
      end
      if (r_state == ST_READ && w_done) r_data_out <= r_oor ? 8'h00 : w_q;
    end
  end
  assign data_out = r_data_out;
  assign rdy = w_rdy;
  assign rd_data_pres = r_state == ST_PRESENT;
  assign max_ram_address = ADDR_W'(2**MEM_AW - 1);
  assign cmd_drop = r_cmd_drop;
  assign addr_err = r_addr_err;
endmodule

// File: tb/tb_ram_byte_responder.sv
// tb_ram_byte_responder: directed self-checking bench for ram_byte_responder
module tb_ram_byte_responder;
  logic systemCLK = 1'b0;
  logic reset, write_enable, read_request, read_ack;
  logic [25:0] address, max_ram_address;
  logic [7:0] data_in, data_out;
  logic rdy, rd_data_pres, cmd_drop, addr_err;
  int total = 0;
  int bad = 0;
  always #5 systemCLK = ~systemCLK;
  ram_byte_responder dut (
    .systemCLK(systemCLK),
    .reset(reset),
    .address(address),
    .data_in(data_in),
    .write_enable(write_enable),
    .read_request(read_request),
    .read_ack(read_ack),
    .data_out(data_out),
    .rdy(rdy),
    .rd_data_pres(rd_data_pres),
    .max_ram_address(max_ram_address),
    .cmd_drop(cmd_drop),
    .addr_err(addr_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge systemCLK);
    #1;
  endtask
  task automatic init_wait;
    for (int i = 1; i <= 17; i++) begin
      tick;
      check("init_rdy", 32'(rdy), 32'(i >= 16));
      check("init_pres", 32'(rd_data_pres), 0);
    end
  endtask
  task automatic do_write(input logic [25:0] a, input logic [7:0] d);
    address = a;
    data_in = d;
    write_enable = 1'b1;
    tick;
    write_enable = 1'b0;
    check("wr_busy", 32'(rdy), 0);
    tick;
    check("wr_done", 32'(rdy), 1);
  endtask
  task automatic do_read(input logic [25:0] a, input logic [7:0] d);
    address = a;
    read_request = 1'b1;
    tick;
    read_request = 1'b0;
    check("rd_lat1", 32'(rd_data_pres), 0);
    tick;
    check("rd_lat2", 32'(rd_data_pres), 0);
    tick;
    check("rd_pres", 32'(rd_data_pres), 1);
    check("rd_data", 32'(data_out), 32'(d));
  endtask
  task automatic do_ack;
    read_ack = 1'b1;
    tick;
    read_ack = 1'b0;
    check("ack_pres", 32'(rd_data_pres), 0);
    check("ack_rdy", 32'(rdy), 1);
  endtask
  initial begin
    reset = 1'b1;
    write_enable = 1'b0;
    read_request = 1'b0;
    read_ack = 1'b0;
    address = '0;
    data_in = '0;
    repeat (3) tick;
    check("rst_rdy", 32'(rdy), 0);
    check("rst_pres", 32'(rd_data_pres), 0);
    check("rst_data", 32'(data_out), 0);
    check("rst_drop", 32'(cmd_drop), 0);
    check("rst_aerr", 32'(addr_err), 0);
    check("max_addr", 32'(max_ram_address), 32'h0000_0FFF);
    reset = 1'b0;
    init_wait;
    check("init_data", 32'(data_out), 0);
    do_write(26'h0A5, 8'h3C);
    do_read(26'h0A5, 8'h3C);
    do_ack;
    address = 26'h010;
    data_in = 8'h77;
    write_enable = 1'b1;
    read_request = 1'b1;
    tick;
    write_enable = 1'b0;
    read_request = 1'b0;
    check("wr_rd_busy", 32'(rdy), 0);
    tick;
    check("wr_rd_lat1", 32'(rd_data_pres), 0);
    tick;
    check("wr_rd_lat2", 32'(rd_data_pres), 0);
    tick;
    check("wr_rd_pres", 32'(rd_data_pres), 1);
    check("wr_rd_data", 32'(data_out), 32'h77);
    address = 26'h0A5;
    read_request = 1'b1;
    tick;
    read_request = 1'b0;
    check("impl_ack_pres", 32'(rd_data_pres), 0);
    check("impl_ack_rdy", 32'(rdy), 0);
    tick;
    tick;
    check("impl_rd_pres", 32'(rd_data_pres), 1);
    check("impl_rd_data", 32'(data_out), 32'h3C);
    do_ack;
    address = 26'h010;
    read_request = 1'b1;
    tick;
    read_request = 1'b0;
    tick;
    address = 26'h0A5;
    read_request = 1'b1;
    tick;
    read_request = 1'b0;
    check("drop_pulse", 32'(cmd_drop), 1);
    check("drop_pres", 32'(rd_data_pres), 1);
    check("drop_data", 32'(data_out), 32'h77);
    tick;
    check("drop_clear", 32'(cmd_drop), 0);
    check("drop_hold", 32'(rd_data_pres), 1);
    do_ack;
    do_write(26'h000, 8'h11);
    address = 26'h001000;
    data_in = 8'h55;
    write_enable = 1'b1;
    tick;
    write_enable = 1'b0;
    check("oor_wr_aerr", 32'(addr_err), 1);
    tick;
    check("oor_wr_aerr_clr", 32'(addr_err), 0);
    check("oor_wr_rdy", 32'(rdy), 1);
    do_read(26'h000, 8'h11);
    do_ack;
    address = 26'h001000;
    read_request = 1'b1;
    tick;
    read_request = 1'b0;
    check("oor_rd_aerr", 32'(addr_err), 1);
    tick;
    check("oor_rd_aerr_clr", 32'(addr_err), 0);
    check("oor_rd_lat", 32'(rd_data_pres), 0);
    tick;
    check("oor_rd_pres", 32'(rd_data_pres), 1);
    check("oor_rd_data", 32'(data_out), 0);
    do_ack;
    do_read(26'h010, 8'h77);
    do_ack;
    address = 26'h0A5;
    read_request = 1'b1;
    tick;
    read_request = 1'b0;
    reset = 1'b1;
    tick;
    check("mid_rst_pres", 32'(rd_data_pres), 0);
    check("mid_rst_rdy", 32'(rdy), 0);
    check("mid_rst_data", 32'(data_out), 0);
    tick;
    reset = 1'b0;
    init_wait;
    do_read(26'h0A5, 8'h3C);
    do_ack;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
